// File: rtl/fetch_mem_pkg.sv
// Shared types and constants for the fetch/load-store memory sequencer.
//   state_e      : sequencer FSM states
//   DEF_*        : default widths and watchdog limit
//   RST_*        : reset values for state and single-bit outputs
package fetch_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int unsigned DEF_AW      = 30;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned DEF_TW      = 8;

  localparam state_e RST_STATE = S_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/port_wait_timer.sv
// Watchdog for one memory-port access.
// Ports:
//   clk, rstb : clock, synchronous active-low reset
//   clr       : hold the count at zero (no access outstanding)
//   en        : count this cycle (request high, no acknowledge)
//   expired   : this cycle is the last allowed wait cycle and it is being counted
module port_wait_timer
  import fetch_mem_pkg::*;
#(
  parameter int unsigned TW      = DEF_TW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Cycle k of an access (1-based) sees cnt_q == k-1, so the last cycle on
  // which an acknowledge is still accepted is cnt_q == TIMEOUT-1.
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/fetch_mem_sequencer.sv
// Sequences instruction fetch and one optional load/store per instruction over
// a single shared memory port, then pulses pc_advance for the fetch unit.
// Ports:
//   clk, rstb                 : clock, synchronous active-low reset
//   fetch_addr                : PC word address, sampled on entry to FETCH
//   mem_rd_req, mem_wr_req    : load/store request from decoder (DECODE only)
//   data_addr, data_wdata     : load/store address and store data (DECODE only)
//   instr, instr_valid        : fetched word and its valid flag
//   rdata                     : last load data
//   pc_advance                : one-cycle PC load enable
//   bus_err                   : sticky watchdog error
//   port_req/we/addr/wdata    : memory request side
//   port_ack, port_rdata      : memory response side
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | after reset, starts first fetch next cycle
// S_FETCH  | instruction read outstanding on the port
// S_DECODE | instr held, decoder requests sampled
// S_DATA   | load or store outstanding on the port
// S_COMMIT | pc_advance high, next fetch follows
// S_HALT   | watchdog fired, waits for reset
module fetch_mem_sequencer
  import fetch_mem_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TW      = DEF_TW
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [AW-1:0] fetch_addr,
  input  logic          mem_rd_req,
  input  logic          mem_wr_req,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [DW-1:0] rdata,
  output logic          pc_advance,
  output logic          bus_err,
  output logic          port_req,
  output logic          port_we,
  output logic [AW-1:0] port_addr,
  output logic [DW-1:0] port_wdata,
  input  logic          port_ack,
  input  logic [DW-1:0] port_rdata
);

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          iv_q, iv_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pc_adv_q, pc_adv_d;
  logic          bus_err_q, bus_err_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic ack_ok;
  logic tmr_expired;
  logic go_halt;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_ok = req_q & port_ack;

  // Request low means no access in flight, which keeps the count at zero so
  // every FETCH/DATA entry starts from a clean count.
  port_wait_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (~req_q),
    .en      (req_q & ~port_ack),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    iv_d      = iv_q;
    rdata_d   = rdata_q;
    pc_adv_d  = 1'b0;
    bus_err_d = bus_err_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    go_halt   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = fetch_addr;
      end
      S_FETCH: begin
        if (ack_ok) begin
          instr_d = port_rdata;
          iv_d    = 1'b1;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          go_halt = 1'b1;
        end
      end
      S_DECODE: begin
        // A store wins when the decoder flags both load and store.
        if (mem_wr_req || mem_rd_req) begin
          state_d = S_DATA;
          req_d   = 1'b1;
          we_d    = mem_wr_req;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else begin
          state_d  = S_COMMIT;
          pc_adv_d = 1'b1;
        end
      end
      S_DATA: begin
        if (ack_ok) begin
          if (!we_q) begin
            rdata_d = port_rdata;
          end
          req_d    = 1'b0;
          we_d     = 1'b0;
          pc_adv_d = 1'b1;
          state_d  = S_COMMIT;
        end else if (tmr_expired) begin
          go_halt = 1'b1;
        end
      end
      S_COMMIT: begin
        state_d = S_FETCH;
        iv_d    = 1'b0;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = fetch_addr;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    if (go_halt) begin
      state_d   = S_HALT;
      req_d     = 1'b0;
      we_d      = 1'b0;
      iv_d      = 1'b0;
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= RST_STATE;
      instr_q   <= '0;
      iv_q      <= RST_FLAG;
      rdata_q   <= '0;
      pc_adv_q  <= RST_FLAG;
      bus_err_q <= RST_FLAG;
      req_q     <= RST_FLAG;
      we_q      <= RST_FLAG;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      iv_q      <= iv_d;
      rdata_q   <= rdata_d;
      pc_adv_q  <= pc_adv_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = iv_q;
  assign rdata       = rdata_q;
  assign pc_advance  = pc_adv_q;
  assign bus_err     = bus_err_q;
  assign port_req    = req_q;
  assign port_we     = we_q;
  assign port_addr   = addr_q;
  assign port_wdata  = wdata_q;

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Scoreboard bench for fetch_mem_sequencer: a memory responder with per-access
// wait states, an expected-event queue filled by the stimulus, and a monitor
// that pops and compares on every acknowledged access and every pc_advance.
module tb_fetch_mem_sequencer;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          mem_rd_req = 1'b0;
  logic          mem_wr_req = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [DW-1:0] rdata;
  logic          pc_advance;
  logic          bus_err;
  logic          port_req;
  logic          port_we;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata;
  logic          port_ack = 1'b0;
  logic [DW-1:0] port_rdata = '0;

  fetch_mem_sequencer #(
    .AW(AW), .DW(DW), .TIMEOUT(4), .TW(8)
  ) dut (
    .clk(clk), .rstb(rstb), .fetch_addr(fetch_addr),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .instr(instr), .instr_valid(instr_valid), .rdata(rdata),
    .pc_advance(pc_advance), .bus_err(bus_err),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ack(port_ack), .port_rdata(port_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder and fetch-unit PC. Fetch addresses live at 0x100000 and
  // above; fetched words are {2'b10, address}. Data reads return data_word.
  int            fetch_dly = 0;
  int            data_dly  = 0;
  logic [DW-1:0] data_word = '0;
  bit            glitch_en = 1'b0;
  logic [AW-1:0] pc = '0;
  int            wait_cnt = 0;

  initial begin
    int  dly;
    bit  is_fetch;
    forever begin
      @(negedge clk);
      if (pc_advance) pc = pc + 1'b1;
      if (port_req) begin
        is_fetch = (port_addr >= 30'h100000);
        dly = is_fetch ? fetch_dly : data_dly;
        if (wait_cnt >= dly) begin
          port_ack   = 1'b1;
          port_rdata = is_fetch ? {2'b10, port_addr} : data_word;
        end else begin
          port_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        port_ack = 1'b0;
        wait_cnt = 0;
      end
      fetch_addr = (glitch_en && port_req && wait_cnt >= 1) ? (pc ^ 30'h3) : pc;
    end
  end

  typedef struct {
    bit            commit;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] instr;
    logic [DW-1:0] rdata;
    bit            iv;
    int            gap;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  last_cyc = 0;

  task automatic check_event(input bit is_commit);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none",
               is_commit ? "commit" : "access", cyc);
    end else begin
      e = exp_q.pop_front();
      chk(is_commit ? "event_kind_commit" : "event_kind_access", is_commit, e.commit);
      if (e.commit == is_commit) begin
        chk("event_gap", cyc - last_cyc, e.gap);
        chk("instr_valid", instr_valid, e.iv);
        chk("bus_err_clear", bus_err, 0);
        if (is_commit) begin
          chk("instr", instr, e.instr);
          chk("rdata", rdata, e.rdata);
        end else begin
          chk("port_we", port_we, e.we);
          chk("port_addr", port_addr, e.addr);
          if (e.we) chk("port_wdata", port_wdata, e.wdata);
        end
      end
    end
    last_cyc = cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rstb) begin
        last_cyc = cyc;
      end else begin
        if (port_req && port_ack) check_event(1'b0);
        if (pc_advance) check_event(1'b1);
      end
    end
  end

  logic [AW-1:0] exp_pc = '0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input bit iv, input int gap);
    ev_t e;
    e.commit = 1'b0; e.we = we; e.addr = a; e.wdata = wd;
    e.instr = '0; e.rdata = '0; e.iv = iv; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_port_req"}, port_req, 0);
    chk({tag, "_port_we"}, port_we, 0);
    chk({tag, "_port_addr"}, port_addr, 0);
    chk({tag, "_port_wdata"}, port_wdata, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_pc_advance"}, pc_advance, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
  endtask

  task automatic do_reset(input logic [AW-1:0] pc0);
    rstb = 1'b0;
    pc = pc0;
    tick();
    tick();
    check_zero("reset");
    exp_pc = pc0;
    exp_rdata = '0;
    rstb = 1'b1;
  endtask

  // One instruction: expected fetch access, optional data access, commit.
  task automatic run_instr(input bit rd, input bit wr, input logic [AW-1:0] daddr,
                           input logic [DW-1:0] wd, input int fd, input int dd);
    ev_t e;
    bit  seen = 1'b0;
    mem_rd_req = rd; mem_wr_req = wr; data_addr = daddr; data_wdata = wd;
    fetch_dly = fd; data_dly = dd;
    push_access(1'b0, exp_pc, '0, 1'b0, 1 + fd);
    if (rd || wr) begin
      push_access(wr, daddr, wd, 1'b1, 2 + dd);
      if (!wr) exp_rdata = data_word;
    end
    e.commit = 1'b1; e.we = 1'b0; e.addr = '0; e.wdata = '0;
    e.instr = {2'b10, exp_pc}; e.rdata = exp_rdata; e.iv = 1'b1;
    e.gap = (rd || wr) ? 1 : 2;
    exp_q.push_back(e);
    exp_pc = exp_pc + 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (pc_advance) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_instr_wait: pc_advance not seen in 60 cycles, expected one");
    end
  endtask

  initial begin
    bit seen;
    bit halt_ok;

    do_reset(30'h100008);

    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, '0, '0, 0, 0);

    data_word = 32'hDEADBEEF;
    run_instr(1'b1, 1'b0, 30'h60, '0, 0, 2);

    run_instr(1'b0, 1'b1, 30'h40, 32'h12345678, 0, 2);

    data_word = 32'h11111111;
    run_instr(1'b1, 1'b1, 30'h50, 32'hCAFEF00D, 0, 0);

    glitch_en = 1'b1;
    run_instr(1'b0, 1'b0, '0, '0, 2, 0);
    glitch_en = 1'b0;

    data_word = 32'h0BADF00D;
    run_instr(1'b1, 1'b0, 30'h70, '0, 3, 3);

    data_word = 32'h55AA55AA;
    run_instr(1'b1, 1'b0, 30'h74, '0, 0, 0);

    // Store that never completes, abandoned by reset while in DATA.
    mem_rd_req = 1'b0; mem_wr_req = 1'b1;
    data_addr = 30'h44; data_wdata = 32'hA5A5A5A5;
    fetch_dly = 0; data_dly = 1000;
    push_access(1'b0, exp_pc, '0, 1'b0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (port_req && port_we) seen = 1'b1;
    end
    chk("reach_data_write", seen, 1);
    rstb = 1'b0;
    tick();
    check_zero("mid_data_reset");
    chk("queue_after_abort", exp_q.size(), 0);
    data_dly = 0; mem_wr_req = 1'b0; exp_rdata = '0;
    rstb = 1'b1;
    run_instr(1'b0, 1'b0, '0, '0, 0, 0);

    // Next fetch is never acknowledged: four wait cycles, then HALT.
    fetch_dly = 1000;
    repeat (4) tick();
    chk("bus_err_before_timeout", bus_err, 0);
    chk("req_held_while_waiting", port_req, 1);
    tick();
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_port_req", port_req, 0);
    chk("timeout_instr_valid", instr_valid, 0);
    chk("timeout_pc_advance", pc_advance, 0);
    halt_ok = 1'b1;
    repeat (8) begin
      tick();
      if (pc_advance || !bus_err || port_req) halt_ok = 1'b0;
    end
    chk("halt_held_until_reset", halt_ok, 1);

    fetch_dly = 0;
    do_reset(30'h200000);
    run_instr(1'b0, 1'b0, '0, '0, 0, 0);
    rstb = 1'b0;
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at 100000 ns, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
